io_pad_bank_ctrl: RTL and testbench

//   Direction sequencer for one bank of WIDTH bidirectional pad cells (DIN/OEN/DOUT/PAD, OEN active-low).
//   - Switches the whole bank between input and output, with guaranteed high-Z turnaround cycles.
//   - Maps per-pin push-pull or open-drain drive onto DIN/OEN.
//   - Synchronises pad readback into the core clock domain.
//   - Sits between the SoC GPIO/peripheral logic and the pad-cell instances.

---
 rtl/io_pad_bank_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_io_pad_bank_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_pad_bank_ctrl.sv
// -----------------------------------------------------------------------------
// io_pad_bank_ctrl
//   Direction sequencer for one bank of WIDTH bidirectional pad cells.
//   The whole bank is switched between input and output. Every direction
//   change passes through TURN_CYCLES high-Z cycles. Per-pin push-pull or
//   open-drain drive is mapped onto the pad DIN/OEN pins, where OEN is
//   active-low. Pad readback is synchronised into the core clock domain.
//
//   Optional feature macro: IO_PAD_FILTER_EN adds a per-pin glitch filter
//   after the synchroniser. It is disabled by default.
//
// Ports
//   clk                in   core clock
//   reset              in   asynchronous reset, active-high
//   io_dirReq_valid    in   direction-change request
//   io_dirReq_payload  in   requested direction (1=output, 0=input)
//   io_dirReq_ready    out  request accepted when valid & ready
//   io_dout            in   core data to drive            [WIDTH]
//   io_openDrain       in   per-pin mode, 1=open-drain    [WIDTH]
//   io_din             out  synchronised pad input        [WIDTH]
//   io_isOutput        out  bank is in state OUT
//   io_pad_din         out  to pad DIN                    [WIDTH]
//   io_pad_oen         out  to pad OEN, 0 = drive         [WIDTH]
//   io_pad_dout        in   from pad DOUT                 [WIDTH]
// -----------------------------------------------------------------------------
module io_pad_bank_ctrl #(
  parameter int WIDTH         = 4,
  parameter int TURN_CYCLES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_dirReq_valid,
  input  logic             io_dirReq_payload,
  output logic             io_dirReq_ready,
  input  logic [WIDTH-1:0] io_dout,
  input  logic [WIDTH-1:0] io_openDrain,
  output logic [WIDTH-1:0] io_din,
  output logic             io_isOutput,
  output logic [WIDTH-1:0] io_pad_din,
  output logic [WIDTH-1:0] io_pad_oen,
  input  logic [WIDTH-1:0] io_pad_dout
);

  // The counter only has to hold TURN_CYCLES-1.
  localparam int CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IN       = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_OUT      = 2'd2,
    ST_TURN_IN  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pad_oen_q, pad_oen_d;
  logic [WIDTH-1:0] pad_din_q, pad_din_d;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic             ready_s;
  logic             is_output_s;
  logic             drive_s;
  logic             accept_s;

  assign accept_s = io_dirReq_valid & ready_s;

  // Next-state and turnaround counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IN: begin
        if (accept_s && io_dirReq_payload) begin
          state_d = ST_TURN_OUT;
          cnt_d   = TURN_LOAD;
        end else begin
          state_d = ST_IN;
          cnt_d   = cnt_q;
        end
      end
      ST_TURN_OUT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_OUT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_TURN_OUT;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (accept_s && !io_dirReq_payload) begin
          state_d = ST_TURN_IN;
          cnt_d   = TURN_LOAD;
        end else begin
          state_d = ST_OUT;
          cnt_d   = cnt_q;
        end
      end
      ST_TURN_IN: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IN;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_TURN_IN;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IN;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State-decoded outputs. The pads are released on the same edge that
  // accepts an OUT->input request, so drive stops before TURN_IN starts.
  always_comb begin
    ready_s     = 1'b0;
    is_output_s = 1'b0;
    drive_s     = 1'b0;
    case (state_q)
      ST_IN: begin
        ready_s = 1'b1;
      end
      ST_OUT: begin
        ready_s     = 1'b1;
        is_output_s = 1'b1;
        drive_s     = ~(io_dirReq_valid & ~io_dirReq_payload);
      end
      ST_TURN_OUT, ST_TURN_IN: begin
        ready_s = 1'b0;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // Pad drive mapping. An open-drain pin only pulls low, so its OEN follows
  // the data while DIN is tied to 0.
  always_comb begin
    pad_oen_d = {WIDTH{1'b1}};
    pad_din_d = {WIDTH{1'b0}};
    if (drive_s) begin
      pad_oen_d = io_openDrain & io_dout;
      pad_din_d = ~io_openDrain & io_dout;
    end else begin
      pad_oen_d = {WIDTH{1'b1}};
      pad_din_d = {WIDTH{1'b0}};
    end
  end

  // Two-stage synchroniser input. It runs in every state, so OUT reads back
  // the bank's own driven level.
  always_comb begin
    sync1_d = io_pad_dout;
    sync2_d = sync1_q;
  end

  // State, counter, pad drive and synchroniser registers. Reset releases the
  // pads without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IN;
      cnt_q     <= {CNT_W{1'b0}};
      pad_oen_q <= {WIDTH{1'b1}};
      pad_din_q <= {WIDTH{1'b0}};
      sync1_q   <= {WIDTH{1'b0}};
      sync2_q   <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pad_oen_q <= pad_oen_d;
      pad_din_q <= pad_din_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
    end
  end

`ifdef IO_PAD_FILTER_EN
  localparam int FCW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0][FCW-1:0] flt_cnt_q, flt_cnt_d;
  logic [WIDTH-1:0]          din_q, din_d;

  // Glitch filter. A pin flips only after FILTER_CYCLES consecutive
  // mismatching samples. Any matching sample restarts the count.
  always_comb begin
    flt_cnt_d = flt_cnt_q;
    din_d     = din_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == din_q[i]) begin
        flt_cnt_d[i] = {FCW{1'b0}};
        din_d[i]     = din_q[i];
      end else if (flt_cnt_q[i] == FLT_LAST) begin
        flt_cnt_d[i] = {FCW{1'b0}};
        din_d[i]     = sync2_q[i];
      end else begin
        flt_cnt_d[i] = flt_cnt_q[i] + FCW'(1);
        din_d[i]     = din_q[i];
      end
    end
  end

  // Filter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flt_cnt_q <= '{default: {FCW{1'b0}}};
      din_q     <= {WIDTH{1'b0}};
    end else begin
      flt_cnt_q <= flt_cnt_d;
      din_q     <= din_d;
    end
  end

  assign io_din = din_q;
`else
  assign io_din = sync2_q;
`endif

  assign io_dirReq_ready = ready_s;
  assign io_isOutput     = is_output_s;
  assign io_pad_oen      = pad_oen_q;
  assign io_pad_din      = pad_din_q;

endmodule

// File: tb/tb_io_pad_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_io_pad_bank_ctrl
//   Scoreboard bench for io_pad_bank_ctrl (WIDTH=4, TURN_CYCLES=2,
//   FILTER_CYCLES=4). Each task queues the expected outputs for a cycle as it
//   drives that cycle's stimulus. After the edge it pops the entry and
//   compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_io_pad_bank_ctrl;

`ifdef IO_PAD_FILTER_EN
  localparam int LAT  = 6;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 2;
  localparam bit FILT = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset  = 1'b0;
  logic       valid  = 1'b0;
  logic       payload = 1'b0;
  logic       ready;
  logic [3:0] dout   = 4'h0;
  logic [3:0] od     = 4'h0;
  logic [3:0] din;
  logic       is_out;
  logic [3:0] pad_din;
  logic [3:0] pad_oen;
  logic [3:0] pad_dout = 4'h0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] oen;
    logic [3:0] pdin;
    logic [3:0] din;
    logic       rdy;
    logic       isout;
  } obs_t;

  obs_t exp_q[$];
  obs_t exp_v;
  obs_t got;

  io_pad_bank_ctrl #(.WIDTH(4), .TURN_CYCLES(2), .FILTER_CYCLES(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .io_dirReq_valid   (valid),
    .io_dirReq_payload (payload),
    .io_dirReq_ready   (ready),
    .io_dout           (dout),
    .io_openDrain      (od),
    .io_din            (din),
    .io_isOutput       (is_out),
    .io_pad_din        (pad_din),
    .io_pad_oen        (pad_oen),
    .io_pad_dout       (pad_dout)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic obs_t sample();
    sample = {pad_oen, pad_din, din, ready, is_out};
  endfunction

  function automatic obs_t mk(input logic [3:0] oen, input logic [3:0] pdin,
                              input logic [3:0] d, input logic rdy, input logic isout);
    mk = {oen, pdin, d, rdy, isout};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    exp_q.push_back(mk(4'hF, 4'h0, 4'h0, 1'b1, 1'b0));
    got = sample(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL reset_no_clk got %h want %h", got, exp_v);
    end
    clk_en = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    exp_q.push_back(mk(4'hF, 4'h0, 4'h0, 1'b1, 1'b0));
    cycle();
    got = sample(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL reset_release got %h want %h", got, exp_v);
    end
  endtask

  task automatic test_to_output();
    logic v_t[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic p_t[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    obs_t e_t[4];
    e_t[0] = mk(4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    e_t[1] = mk(4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    e_t[2] = mk(4'hF, 4'h0, 4'h0, 1'b1, 1'b1);
    e_t[3] = mk(4'h0, 4'hA, 4'h0, 1'b1, 1'b1);
    dout = 4'hA; od = 4'h0;
    for (int i = 0; i < 4; i++) begin
      valid = v_t[i]; payload = p_t[i];
      exp_q.push_back(e_t[i]);
      cycle();
      got = sample(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL to_output[%0d] got %h want %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_open_drain();
    logic [3:0] od_t[6]   = '{4'h3, 4'hF, 4'hF, 4'h0, 4'hC, 4'h0};
    logic [3:0] dout_t[6] = '{4'h5, 4'h0, 4'hF, 4'h5, 4'h6, 4'h3};
    logic [3:0] oen_t[6]  = '{4'h1, 4'h0, 4'hF, 4'h0, 4'h4, 4'h0};
    logic [3:0] pdin_t[6] = '{4'h4, 4'h0, 4'h0, 4'h5, 4'h2, 4'h3};
    for (int i = 0; i < 6; i++) begin
      od = od_t[i]; dout = dout_t[i];
      // last entry also issues a same-direction request, which must be a no-op
      valid = (i == 5); payload = 1'b1;
      exp_q.push_back(mk(oen_t[i], pdin_t[i], 4'h0, 1'b1, 1'b1));
      cycle();
      got = sample(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL open_drain[%0d] got %h want %h", i, got, exp_v);
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_to_input();
    logic v_t[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    obs_t e_t[5];
    e_t[0] = mk(4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    e_t[1] = mk(4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    e_t[2] = mk(4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
    e_t[3] = mk(4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
    e_t[4] = mk(4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      valid = v_t[i]; payload = 1'b0;
      exp_q.push_back(e_t[i]);
      cycle();
      got = sample(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL to_input[%0d] got %h want %h", i, got, exp_v);
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_sync();
    // steady rise on pin 0
    pad_dout = 4'h1;
    for (int k = 1; k <= LAT + 1; k++) begin
      exp_q.push_back(mk(4'hF, 4'h0, (k >= LAT) ? 4'h1 : 4'h0, 1'b1, 1'b0));
      cycle();
      got = sample(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL sync_rise[%0d] got %h want %h", k, got, exp_v);
      end
    end
    // steady fall back to 0
    pad_dout = 4'h0;
    for (int k = 1; k <= LAT + 1; k++) begin
      exp_q.push_back(mk(4'hF, 4'h0, (k >= LAT) ? 4'h0 : 4'h1, 1'b1, 1'b0));
      cycle();
      got = sample(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL sync_fall[%0d] got %h want %h", k, got, exp_v);
      end
    end
    // one-cycle glitch on pin 1
    for (int k = 1; k <= 8; k++) begin
      pad_dout = (k == 1) ? 4'h2 : 4'h0;
      exp_q.push_back(mk(4'hF, 4'h0, (!FILT && k == 2) ? 4'h2 : 4'h0, 1'b1, 1'b0));
      cycle();
      got = sample(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL sync_glitch[%0d] got %h want %h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    dout = 4'h3; od = 4'h0;
    // reset while in TURN_OUT
    valid = 1'b1; payload = 1'b1;
    exp_q.push_back(mk(4'hF, 4'h0, 4'h0, 1'b0, 1'b0));
    cycle();
    valid = 1'b0;
    got = sample(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL mid_turn_enter got %h want %h", got, exp_v);
    end
    #2 reset = 1'b1;
    #1;
    exp_q.push_back(mk(4'hF, 4'h0, 4'h0, 1'b1, 1'b0));
    got = sample(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL mid_turn_reset got %h want %h", got, exp_v);
    end
    cycle();
    reset = 1'b0;
    // reach OUT with pads driven, then reset
    valid = 1'b1; payload = 1'b1;
    cycle();
    valid = 1'b0;
    cycle();
    cycle();
    exp_q.push_back(mk(4'h0, 4'h3, 4'h0, 1'b1, 1'b1));
    cycle();
    got = sample(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL mid_out_enter got %h want %h", got, exp_v);
    end
    #2 reset = 1'b1;
    #1;
    exp_q.push_back(mk(4'hF, 4'h0, 4'h0, 1'b1, 1'b0));
    got = sample(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL mid_out_reset got %h want %h", got, exp_v);
    end
    cycle();
    reset = 1'b0;
    // first request after release takes the normal path
    for (int i = 0; i < 4; i++) begin
      valid = (i == 0); payload = 1'b1;
      case (i)
        0, 1:    exp_q.push_back(mk(4'hF, 4'h0, 4'h0, 1'b0, 1'b0));
        2:       exp_q.push_back(mk(4'hF, 4'h0, 4'h0, 1'b1, 1'b1));
        default: exp_q.push_back(mk(4'h0, 4'h3, 4'h0, 1'b1, 1'b1));
      endcase
      cycle();
      got = sample(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL post_reset_req[%0d] got %h want %h", i, got, exp_v);
      end
    end
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_to_output();
    test_open_drain();
    test_to_input();
    test_sync();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
